// File: rtl/lilme_pkg.sv
// LilME shared definitions: engine opcodes and command arbiter state encoding.
// Imported by the arbiter and by other LilME_controller users.
package lilme_pkg;

    localparam int ME_OPW = 3;

    localparam logic [2:0] ME_NOP      = 3'b000;
    localparam logic [2:0] ME_LOAD     = 3'b001;
    localparam logic [2:0] ME_SET_ROW  = 3'b010;
    localparam logic [2:0] ME_SET_COL  = 3'b011;
    localparam logic [2:0] ME_MUL      = 3'b100;
    localparam logic [2:0] ME_MAC      = 3'b101;
    localparam logic [2:0] ME_CLEAR    = 3'b110;
    localparam logic [2:0] ME_READ_MUL = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_START,
        ST_WAIT_END,
        ST_DONE
    } arb_state_e;

    // These ops finish inside the engine without ever raising Busy.
    function automatic logic me_no_busy(input logic [2:0] op);
        return (op == ME_SET_ROW) || (op == ME_SET_COL) || (op == ME_CLEAR);
    endfunction

endpackage

// File: rtl/lilme_rr_pick.sv
// Round-robin pick: first valid requester at or after ptr, wrapping.
// Purely combinational; idx is meaningless when any is 0.
module lilme_rr_pick
    import lilme_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         valid,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic                       any,
    output logic [$clog2(NUM_REQ)-1:0] idx
);

    localparam int IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] rot;
    logic [IW:0]        off;
    logic [IW:0]        sum;

    assign rot = NUM_REQ'({valid, valid} >> ptr);

    always_comb begin
        off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) off = (IW + 1)'(k);
        end
    end

    assign sum = off + {1'b0, ptr};
    assign any = |valid;
    assign idx = (sum >= (IW + 1)'(NUM_REQ))
               ? IW'(sum - (IW + 1)'(NUM_REQ))
               : IW'(sum);

endmodule

// File: rtl/lilme_cmd_arbiter.sv
// Round-robin command arbiter sharing one LilME matrix engine.
// Issues one opcode per grant and holds the grant until Busy completes.
module lilme_cmd_arbiter
    import lilme_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int OPW       = 3,
    parameter int START_TMO = 8,
    parameter int RUN_TMO   = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [OPW*NUM_REQ-1:0]     req_opcode,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         req_done,
    output logic                       req_err,
    output logic [OPW-1:0]             me_opcode,
    input  logic                       me_busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       arb_busy
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(RUN_TMO + 1);

    localparam logic [NUM_REQ-1:0] ONE       = NUM_REQ'(1);
    localparam logic [CW-1:0]      START_LIM = CW'(START_TMO - 1);
    localparam logic [CW-1:0]      RUN_LIM   = CW'(RUN_TMO - 1);

    arb_state_e     state;
    logic [OPW-1:0] op_q;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_inc;
    logic [IW-1:0]  rr_ptr;
    logic           pick_any;
    logic [IW-1:0]  pick_idx;
    logic [OPW-1:0] pick_op;
    logic           quick;

    lilme_rr_pick #(
        .NUM_REQ(NUM_REQ)
    ) u_pick (
        .valid(req_valid),
        .ptr  (rr_ptr),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    always_comb begin
        pick_op = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IW'(i)) pick_op = req_opcode[i*OPW +: OPW];
        end
    end

    assign quick   = me_no_busy(op_q[2:0]);
    assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            grant_id  <= '0;
            op_q      <= '0;
            cnt       <= '0;
            req_ready <= '0;
            req_done  <= '0;
            req_err   <= 1'b0;
            me_opcode <= '0;
            arb_busy  <= 1'b0;
        end else begin
            req_ready <= '0;
            req_done  <= '0;
            req_err   <= 1'b0;
            me_opcode <= '0;
            unique case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        state     <= ST_ISSUE;
                        grant_id  <= pick_idx;
                        op_q      <= pick_op;
                        me_opcode <= pick_op;
                        req_ready <= ONE << pick_idx;
                        arb_busy  <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    cnt <= '0;
                    if (op_q == '0) begin
                        state    <= ST_DONE;
                        req_done <= ONE << grant_id;
                    end else begin
                        state <= ST_WAIT_START;
                    end
                end
                ST_WAIT_START: begin
                    if (me_busy) begin
                        state <= ST_WAIT_END;
                        cnt   <= '0;
                    end else if (quick && cnt == CW'(1)) begin
                        state    <= ST_DONE;
                        req_done <= ONE << grant_id;
                    end else if (cnt >= START_LIM) begin
                        state    <= ST_DONE;
                        req_done <= ONE << grant_id;
                        req_err  <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                ST_WAIT_END: begin
                    if (!me_busy) begin
                        state    <= ST_DONE;
                        req_done <= ONE << grant_id;
                    end else if (cnt >= RUN_LIM) begin
                        state    <= ST_DONE;
                        req_done <= ONE << grant_id;
                        req_err  <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                ST_DONE: begin
                    state    <= ST_IDLE;
                    arb_busy <= 1'b0;
                    rr_ptr   <= (grant_id == IW'(NUM_REQ - 1))
                              ? '0 : grant_id + 1'b1;
                end
                default: begin
                    state    <= ST_IDLE;
                    arb_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lilme_cmd_arbiter.sv
// Bench for lilme_cmd_arbiter: age-based reference model checked every cycle,
// plus directed scenarios with hand-computed pulse timings.
module tb_lilme_cmd_arbiter;

    localparam int N   = 3;
    localparam int OPW = 3;
    localparam int ST  = 8;
    localparam int RT  = 1024;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [OPW*N-1:0] req_opcode;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   req_done;
    logic           req_err;
    logic [OPW-1:0] me_opcode;
    logic           me_busy;
    logic [1:0]     grant_id;
    logic           arb_busy;

    lilme_cmd_arbiter #(
        .NUM_REQ(N), .OPW(OPW), .START_TMO(ST), .RUN_TMO(RT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_opcode(req_opcode),
        .req_ready (req_ready),
        .req_done  (req_done),
        .req_err   (req_err),
        .me_opcode (me_opcode),
        .me_busy   (me_busy),
        .grant_id  (grant_id),
        .arb_busy  (arb_busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic bit is_quick(input logic [2:0] o);
        return (o == 3'b010) || (o == 3'b011) || (o == 3'b110);
    endfunction

    // Engine stand-in: manual Busy, or Busy for eng_len cycles per busy-type op.
    bit  eng_auto = 1'b0;
    bit  man_busy = 1'b0;
    int  eng_len  = 3;
    int  eng_left = 0;

    always @(negedge clk) begin
        if (me_opcode != '0 && !is_quick(me_opcode)) eng_left = eng_len;
        else if (eng_left > 0) eng_left--;
    end

    assign me_busy = eng_auto ? (eng_left > 0) : man_busy;

    // Reference model: tracks age of the current command since acceptance.
    bit             m_act = 1'b0, m_fin = 1'b0, f_now, f_err;
    int             m_rr = 0, m_g = 0, m_age = 0, m_rise = 0;
    logic [OPW-1:0] m_op = '0;
    logic [N-1:0]   e_ready = '0, e_done = '0;
    logic           e_err = 1'b0, e_busy = 1'b0;
    logic [OPW-1:0] e_op = '0;
    int             e_gid = 0;

    always @(posedge clk) begin
        e_ready = '0;
        e_done  = '0;
        e_err   = 1'b0;
        e_op    = '0;
        f_now   = 1'b0;
        f_err   = 1'b0;
        if (reset) begin
            m_act  = 1'b0;
            m_fin  = 1'b0;
            m_rr   = 0;
            e_gid  = 0;
            e_busy = 1'b0;
        end else if (!m_act) begin
            e_busy = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (!m_act && req_valid[(m_rr + k) % N]) begin
                    m_act = 1'b1;
                    m_g   = (m_rr + k) % N;
                end
            end
            if (m_act) begin
                m_op   = req_opcode[m_g*OPW +: OPW];
                m_age  = 1;
                m_rise = 0;
                m_fin  = 1'b0;
                e_ready[m_g] = 1'b1;
                e_op   = m_op;
                e_gid  = m_g;
                e_busy = 1'b1;
            end
        end else if (m_fin) begin
            m_act  = 1'b0;
            m_fin  = 1'b0;
            m_rr   = (m_g + 1) % N;
            e_busy = 1'b0;
        end else begin
            if (m_age == 1) begin
                if (m_op == '0) f_now = 1'b1;
            end else if (m_rise == 0) begin
                if (me_busy) m_rise = m_age;
                else if (is_quick(m_op) && m_age == 3) f_now = 1'b1;
                else if (m_age == ST + 1) begin f_now = 1'b1; f_err = 1'b1; end
            end else if (!me_busy) begin
                f_now = 1'b1;
            end else if (m_age - m_rise == RT) begin
                f_now = 1'b1;
                f_err = 1'b1;
            end
            m_age++;
            m_fin = f_now;
            if (f_now) begin
                e_done[m_g] = 1'b1;
                e_err = f_err;
            end
            e_busy = 1'b1;
        end
    end

    // Per-cycle compare plus event log for the directed pins.
    int         ready_cyc, done_cyc, done_cnt, op_cnt, busy_cnt;
    logic [N-1:0] ready_mask, done_mask;
    logic       done_err;
    int         grants[$];

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", 32'(req_ready), 32'(e_ready));
            chk("done", 32'(req_done), 32'(e_done));
            chk("err", 32'(req_err), 32'(e_err));
            chk("me_op", 32'(me_opcode), 32'(e_op));
            chk("gid", 32'(grant_id), 32'(e_gid));
            chk("arb_busy", 32'(arb_busy), 32'(e_busy));
        end
        if (|req_ready) begin
            ready_cyc = cyc;
            ready_mask |= req_ready;
            grants.push_back(int'(grant_id));
        end
        if (|req_done) begin
            done_cyc = cyc;
            done_mask |= req_done;
            done_err = req_err;
            done_cnt++;
        end
        if (me_opcode != '0) op_cnt++;
        if (arb_busy) busy_cnt++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clr;
        ready_cyc = 0; done_cyc = 0; done_cnt = 0; op_cnt = 0;
        busy_cnt = 0; ready_mask = '0; done_mask = '0; done_err = 1'b0;
        grants.delete();
    endtask

    task automatic set_op(input int i, input logic [2:0] op);
        req_opcode[i*OPW +: OPW] = op;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (arb_busy && n < budget);
        if (arb_busy) chk({nm, "_idle_timeout"}, 32'(arb_busy), 32'd0);
    endtask

    task automatic wait_done(input string nm, input int cnt, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (done_cnt < cnt && n < budget);
        if (done_cnt < cnt) chk({nm, "_done_timeout"}, 32'(done_cnt), 32'(cnt));
    endtask

    int t0;

    initial begin
        reset = 1'b1;
        req_valid = '0;
        req_opcode = '0;
        clr();
        tick();
        chk_en = 1'b1;
        tick();
        @(negedge clk);
        chk("rst_gid", 32'(grant_id), 32'd0);
        chk("rst_arb_busy", 32'(arb_busy), 32'd0);
        chk("rst_me_op", 32'(me_opcode), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        tick();
        reset = 1'b0;

        // 1: single op 101 on req 0, engine busy 20 cycles
        clr();
        set_op(0, 3'b101);
        req_valid = 3'b001;
        t0 = cyc;
        tick();
        req_valid = '0;
        tick();
        man_busy = 1'b1;
        repeat (20) tick();
        man_busy = 1'b0;
        wait_idle("t1", 20);
        chk("t1_latency", 32'(ready_cyc - t0), 32'd1);
        chk("t1_op_cycles", 32'(op_cnt), 32'd1);
        chk("t1_ready", 32'(ready_mask), 32'b001);
        chk("t1_done", 32'(done_mask), 32'b001);
        chk("t1_err", 32'(done_err), 32'd0);
        chk("t1_span", 32'(done_cyc - ready_cyc), 32'd22);

        // 2: req 0 and 1 both valid; grants alternate starting at 0
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clr();
        eng_auto = 1'b1;
        eng_len = 3;
        set_op(0, 3'b101);
        set_op(1, 3'b101);
        req_valid = 3'b011;
        wait_done("t2", 4, 100);
        req_valid = '0;
        wait_idle("t2", 10);
        chk("t2_grants", 32'(grants.size()), 32'd4);
        for (int i = 0; i < grants.size() && i < 4; i++)
            chk("t2_order", 32'(grants[i]), 32'(i % 2));
        chk("t2_done", 32'(done_mask), 32'b011);

        // 3: NOP on req 1 -> 3 cycles IDLE to IDLE, engine untouched
        clr();
        eng_auto = 1'b0;
        set_op(1, 3'b000);
        req_valid = 3'b010;
        tick();
        req_valid = '0;
        wait_idle("t3", 10);
        chk("t3_ready", 32'(ready_mask), 32'b010);
        chk("t3_done", 32'(done_mask), 32'b010);
        chk("t3_span", 32'(done_cyc - ready_cyc), 32'd1);
        chk("t3_op_cycles", 32'(op_cnt), 32'd0);
        chk("t3_turnaround", 32'(busy_cnt + 1), 32'd3);

        // 4: engine never busy -> timeout START_TMO+1 after issue
        clr();
        set_op(0, 3'b101);
        req_valid = 3'b001;
        tick();
        req_valid = '0;
        wait_idle("t4", 30);
        chk("t4_span", 32'(done_cyc - ready_cyc), 32'(ST + 1));
        chk("t4_err", 32'(done_err), 32'd1);
        chk("t4_done", 32'(done_mask), 32'b001);

        // 4b: busy-less opcode completes after 2 quiet cycles
        clr();
        set_op(2, 3'b010);
        req_valid = 3'b100;
        tick();
        req_valid = '0;
        wait_idle("t4b", 20);
        chk("t4b_ready", 32'(ready_mask), 32'b100);
        chk("t4b_span", 32'(done_cyc - ready_cyc), 32'd3);
        chk("t4b_err", 32'(done_err), 32'd0);

        // 5: Busy stuck high -> run timeout, then a normal grant
        clr();
        man_busy = 1'b1;
        set_op(1, 3'b101);
        req_valid = 3'b010;
        tick();
        req_valid = '0;
        wait_idle("t5", RT + 20);
        chk("t5_span", 32'(done_cyc - ready_cyc), 32'(RT + 2));
        chk("t5_err", 32'(done_err), 32'd1);
        chk("t5_done", 32'(done_mask), 32'b010);
        man_busy = 1'b0;
        clr();
        eng_auto = 1'b1;
        eng_len = 3;
        set_op(2, 3'b100);
        req_valid = 3'b100;
        tick();
        req_valid = '0;
        wait_idle("t5b", 30);
        chk("t5b_done", 32'(done_mask), 32'b100);
        chk("t5b_err", 32'(done_err), 32'd0);

        // 6: reset during WAIT_END abandons the command silently
        clr();
        eng_len = 50;
        set_op(1, 3'b101);
        req_valid = 3'b010;
        tick();
        req_valid = '0;
        repeat (6) tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        chk("t6_ready", 32'(req_ready), 32'd0);
        chk("t6_done", 32'(req_done), 32'd0);
        chk("t6_err", 32'(req_err), 32'd0);
        chk("t6_me_op", 32'(me_opcode), 32'd0);
        chk("t6_arb_busy", 32'(arb_busy), 32'd0);
        chk("t6_gid", 32'(grant_id), 32'd0);
        reset = 1'b0;
        eng_auto = 1'b0;
        repeat (5) tick();
        chk("t6_no_done", 32'(done_cnt), 32'd0);
        clr();
        set_op(0, 3'b110);
        set_op(1, 3'b110);
        set_op(2, 3'b110);
        req_valid = 3'b111;
        tick();
        req_valid = '0;
        wait_idle("t6b", 20);
        chk("t6b_ready", 32'(ready_mask), 32'b001);
        chk("t6b_done", 32'(done_mask), 32'b001);
        chk("t6b_err", 32'(done_err), 32'd0);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
